// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the chord datapath voice allocator: widths, the rest
// code, per-slot state encodings and the MCU state encodings.
package voice_allocator_pkg;

  localparam int unsigned NumVoices = 3;
  localparam int unsigned NoteW     = 6;
  localparam int unsigned DurW      = 6;

  localparam logic [NoteW-1:0] NoteRest = '0;

  typedef enum logic {
    SlotIdle = 1'b0,
    SlotHold = 1'b1
  } slot_state_e;

  typedef enum logic [1:0] {
    McuReset = 2'd0,
    McuPause = 2'd1,
    McuPlay  = 2'd2
  } mcu_state_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake from the song reader (master) to the voice allocator
// (slave).
interface voice_allocator_if #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6
);
  logic              valid;
  logic              ready;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  dur;

  modport master (output valid, output note, output dur, input ready);
  modport slave  (input valid, input note, input dur, output ready);
endinterface

// File: rtl/voice_allocator_voice_slot.sv
// One voice slot: holds a note for a programmed number of play-time beats and
// pulses load for one cycle whenever it latches a new note.
module voice_slot
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NOTE_W = NoteW,
  parameter int unsigned DUR_W  = DurW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              flush,
  input  logic              tick,
  input  logic [NOTE_W-1:0] alloc_note,
  input  logic [DUR_W-1:0]  alloc_dur,
  output logic              active,
  output logic [NOTE_W-1:0] note,
  output logic              load
);

  slot_state_e       state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic              load_q, load_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SlotIdle;
      note_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    if (flush) begin
      state_d = SlotIdle;
      note_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SlotIdle: begin
          if (alloc) begin
            state_d = SlotHold;
            note_d  = alloc_note;
            cnt_d   = alloc_dur;
            load_d  = 1'b1;
          end
        end
        SlotHold: begin
          // Counter is always >= 1 in hold, so it never wraps.
          if (tick) begin
            if (cnt_q == DUR_W'(1)) begin
              state_d = SlotIdle;
              note_d  = '0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - DUR_W'(1);
            end
          end
        end
        default: begin
          state_d = SlotIdle;
          note_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign active = (state_q == SlotHold);
  assign note   = note_q;
  assign load   = load_q;

endmodule

// File: rtl/voice_allocator.sv
// Assigns incoming note events to the lowest-index free voice slot; rests and
// zero-length events are consumed without occupying a slot.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NumVoices,
  parameter int unsigned NOTE_W     = NoteW,
  parameter int unsigned DUR_W      = DurW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         flush,
  input  logic                         beat,
  voice_allocator_if.slave             ev,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic                         all_busy
);

  logic [NUM_VOICES-1:0] free_slot;
  logic [NUM_VOICES-1:0] first_free;
  logic [NUM_VOICES-1:0] alloc;
  logic                  skip;
  logic                  accept;
  logic                  tick;

  // Free slots come from registered state, so a slot expiring this cycle
  // is only reusable next cycle.
  assign free_slot  = ~voice_active;
  assign first_free = free_slot & (~free_slot + NUM_VOICES'(1));

  assign skip     = (ev.note == NoteRest) | (ev.dur == '0);
  assign ev.ready = play & ~flush & (skip | (|free_slot));
  assign accept   = ev.valid & ev.ready;
  assign alloc    = (accept & ~skip) ? first_free : '0;
  assign tick     = play & beat;
  assign all_busy = &voice_active;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .NOTE_W (NOTE_W),
      .DUR_W  (DUR_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc[g]),
      .flush      (flush),
      .tick       (tick),
      .alloc_note (ev.note),
      .alloc_dur  (ev.dur),
      .active     (voice_active[g]),
      .note       (voice_note[g*NOTE_W +: NOTE_W]),
      .load       (voice_load[g])
    );
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios followed by random
// traffic, all compared against a slot-level reference model.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int NV = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          play  = 1'b0;
  logic          flush = 1'b0;
  logic          beat  = 1'b0;
  logic [NV-1:0] voice_active;
  logic [NV*6-1:0] voice_note;
  logic [NV-1:0] voice_load;
  logic          all_busy;

  voice_allocator_if #(.NOTE_W(6), .DUR_W(6)) ev ();

  voice_allocator dut (
    .clk          (clk),
    .reset        (rst_n),
    .play         (play),
    .flush        (flush),
    .beat         (beat),
    .ev           (ev),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .voice_load   (voice_load),
    .all_busy     (all_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one entry per voice slot.
  bit m_act[NV];
  int m_note[NV];
  int m_rem[NV];
  bit m_load[NV];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_rem[i] = 0; m_load[i] = 0;
    end
  endtask

  task automatic compare_outputs();
    logic [31:0] act, note, ld;
    bit busy;
    act = '0; note = '0; ld = '0; busy = 1;
    for (int i = 0; i < NV; i++) begin
      act[i] = m_act[i];
      ld[i]  = m_load[i];
      note   = note | (32'(m_note[i] & 63) << (6 * i));
      busy   = busy & m_act[i];
    end
    check_eq("voice_active", 32'(voice_active), act);
    check_eq("voice_note", 32'(voice_note), note);
    check_eq("voice_load", 32'(voice_load), ld);
    check_eq("all_busy", 32'(all_busy), 32'(busy));
  endtask

  // Called at a falling edge: drive inputs, check in_ready, advance the model,
  // then compare registered outputs at the next falling edge.
  task automatic step(input bit v, input int n, input int d, input bit p, input bit b,
                      input bit f);
    bit ready_exp, skip, any_free, placed;
    bit was_free[NV];
    ev.valid = v;
    ev.note  = 6'(n);
    ev.dur   = 6'(d);
    play     = p;
    beat     = b;
    flush    = f;
    #1;
    skip     = (n == 0) || (d == 0);
    any_free = 0;
    for (int i = 0; i < NV; i++) if (!m_act[i]) any_free = 1;
    ready_exp = p && !f && (skip || any_free);
    check_eq("in_ready", 32'(ev.ready), 32'(ready_exp));
    if (f) begin
      model_clear();
    end else begin
      for (int i = 0; i < NV; i++) begin
        was_free[i] = !m_act[i];
        m_load[i]   = 0;
      end
      if (p && b) begin
        for (int i = 0; i < NV; i++) begin
          if (m_act[i]) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
              m_act[i] = 0; m_note[i] = 0;
            end
          end
        end
      end
      if (v && ready_exp && !skip) begin
        placed = 0;
        for (int i = 0; i < NV; i++) begin
          if (!placed && was_free[i]) begin
            placed = 1; m_act[i] = 1; m_note[i] = n; m_rem[i] = d; m_load[i] = 1;
          end
        end
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ev.valid = 0; ev.note = 0; ev.dur = 0;
    play = 0; beat = 0; flush = 0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_outputs();
  endtask

  initial begin
    ev.valid = 0; ev.note = 0; ev.dur = 0;
    @(negedge clk);
    do_reset();

    // Fill all three slots back to back; the fourth event stalls.
    step(1, 10, 2, 1, 0, 0);
    step(1, 20, 3, 1, 0, 0);
    step(1, 30, 4, 1, 0, 0);
    check_eq("fill_busy", 32'(all_busy), 32'd1);
    step(1, 40, 5, 1, 0, 0);
    // Two beats: slot 0 expires, stalled event lands in slot 0 afterwards.
    step(1, 40, 5, 1, 1, 0);
    step(1, 40, 5, 1, 1, 0);
    check_eq("slot0_expired", 32'(voice_active[0]), 32'd0);
    step(1, 40, 5, 1, 0, 0);
    check_eq("stall_into_slot0", 32'(voice_note[5:0]), 32'd40);

    // Pause freezes the counter.
    step(0, 0, 0, 1, 0, 1);
    step(1, 15, 3, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    check_eq("pause_hold", 32'(voice_note[5:0]), 32'd15);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    check_eq("resume_still_held", 32'(voice_active[0]), 32'd1);
    step(0, 0, 0, 1, 1, 0);
    check_eq("resume_expired", 32'(voice_active[0]), 32'd0);

    // Rest and zero-duration events are consumed with no slot change.
    step(1, 0, 5, 1, 0, 0);
    step(1, 12, 0, 1, 0, 0);

    // Flush with two voices held, concurrent event and beat.
    step(1, 21, 4, 1, 0, 0);
    step(1, 22, 4, 1, 0, 0);
    step(1, 23, 4, 1, 1, 1);
    check_eq("flush_clear", 32'(voice_active), 32'd0);
    step(1, 23, 4, 1, 0, 0);
    check_eq("after_flush_slot0", 32'(voice_note[5:0]), 32'd23);

    // Asynchronous reset mid-hold.
    step(1, 33, 6, 1, 0, 0);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    ev.valid = 0;
    compare_outputs();
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 44, 2, 1, 0, 0);

    // Random traffic.
    step(0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 9) < 6),
           (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63))),
           int'($urandom_range(0, 6)),
           ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Schedules the chord datapath's note-player voices. It accepts note events from the song reader over a valid/ready handshake and assigns each event to a free voice slot. Each slot holds its note for a programmed number of beats while the player is in PLAY. The block sits between the song reader and the bank of note players, downstream of the MCU's `play` and `reset_player` outputs.

## Interface

- NUM_VOICES, 3, number of voice slots / note players
- NOTE_W, 6, note code width; code 0 = rest
- DUR_W, 6, duration width in beats

- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- play  input  1  from MCU; 1 = PLAY state, timers run and notes accepted
- flush  input  1  from MCU reset_player; one-cycle pulse, abort all voices
- beat  input  1  one-cycle beat strobe
- in_valid  input  1  song reader offers an event
- in_ready  output  1  event consumed this cycle when in_valid & in_ready
- in_note  input  NOTE_W  note code of offered event
- in_dur  input  DUR_W  duration in beats of offered event
- voice_active  output  NUM_VOICES  slot i is holding a note
- voice_note  output  NUM_VOICES*NOTE_W  slot i note in bits [i*NOTE_W +: NOTE_W]; 0 when inactive
- voice_load  output  NUM_VOICES  one-cycle pulse: slot i loaded a new note, so the player restarts its phase
- all_busy  output  1  every slot active

## Operation

- Per-slot state machine with two states:
  - IDLE: active=0, note=0.
  - HOLD: active=1, note and remaining-beat counter are valid.
- IDLE→HOLD on allocation: note latched, counter = in_dur, voice_load pulses.
- HOLD→IDLE when play & beat and counter==1.
- Otherwise in HOLD, play & beat decrements the counter. The counter never underflows.
- With play=0, all counters freeze. Notes stay held and outputs stay unchanged, so pause resumes seamlessly.
- in_ready = play & ~flush & (in_note==0 | in_dur==0 | any slot IDLE). in_ready never depends on in_valid.
- An event with in_note==0 (rest) or in_dur==0 is consumed without touching any slot.
- Allocation goes to the lowest-index IDLE slot, judged from registered state.
  - A slot expiring this cycle is not reusable until the next cycle.
- When no slot is free, in_ready stays low and the song reader stalls. Voices are never stolen.
- flush takes priority over everything: all slots go to IDLE next cycle, and any offered event is not consumed.
- all_busy = &voice_active.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert is assumed at the system level):
  - all slots IDLE, voice_active=0, voice_note=0, voice_load=0, all_busy=0.
- in_ready is combinational.
- Handshake to output: voice_active, voice_note and voice_load are updated at the clock edge after the handshake, so latency is 1 cycle.
- Expiry: the voice is inactive in the cycle after the beat on which the counter was 1.
  - A note with in_dur=D loaded while beats keep arriving is cleared after exactly its D-th beat strobe following load.
- A beat arriving in the same cycle as the load is not counted against the new note.
- Simultaneous flush and beat: flush wins and all counters clear.
- Reset mid-hold: immediate clear, no voice_load pulses.

## Structure

- Shared defines header: NOTE_REST (0) and the slot state encodings SLOT_IDLE and SLOT_HOLD. The MCU state defines live alongside them.
- Sub-module voice_slot: one per slot, built by a generate loop. It contains the state, note register, duration counter and load pulse register.
  - Inputs: alloc, flush, tick (play & beat), note, dur.
  - Outputs: active, note, load.
- Top level holds the lowest-free priority encoder and the in_ready logic.

## Test plan

- Reset then 3 back-to-back events (note 10/dur 2, 20/3, 30/4) with play=1:
  - slots 0,1,2 loaded on successive cycles, each with one voice_load pulse.
  - all_busy=1.
  - a 4th event sees in_ready=0.
- Same fill, then 2 beats:
  - slot 0 goes idle after beat 2.
  - the stalled 4th event (note 40) is accepted the following cycle into slot 0.
- Hold a note of dur 3, drop play to 0 and issue 5 beats:
  - no change.
  - restore play: the voice clears after exactly 3 further beats.
- Rest event (note 0, dur 5) and a zero-duration event (note 12, dur 0):
  - both are consumed with in_ready=1.
  - no voice_active or voice_load change.
- With 2 voices held, pulse flush together with in_valid and beat:
  - all voices clear next cycle and the event is not consumed.
  - the event is accepted the following cycle into slot 0.
- Assert reset for one cycle mid-hold with play=1:
  - outputs zero immediately, asynchronous to clk.
  - they stay zero until the next handshake.
